// File: rtl/sme_param_if.sv
// Byte-stream load/result bus of the string-matching engine.
interface sme_param_if #(
    parameter int unsigned IDX_W = 5
);
    logic [7:0]       chardata;
    logic             isstring;
    logic             ispattern;
    logic             valid;
    logic             match;
    logic [IDX_W-1:0] match_index;
    logic             busy;

    modport master (
        output chardata, isstring, ispattern,
        input  valid, match, match_index, busy
    );

    modport slave (
        input  chardata, isstring, ispattern,
        output valid, match, match_index, busy
    );
endinterface

// File: rtl/sme_param.sv
// Parametrised string-matching engine: stores a string, then searches it for
// each streamed pattern ('^', '$', '.', one '*') and pulses a one-cycle result.
module sme_param #(
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned IDX_W   = $clog2(STR_MAX)
) (
    input logic        clk,
    input logic        reset,
    sme_param_if.slave bus
);

    localparam int unsigned LEN_W  = $clog2(STR_MAX + 1);
    localparam int unsigned PLEN_W = $clog2(PAT_MAX + 1);
    localparam int unsigned PIDX_W = $clog2(PAT_MAX);

    localparam logic [LEN_W-1:0]  STR_MAX_L = LEN_W'(STR_MAX);
    localparam logic [PLEN_W-1:0] PAT_MAX_L = PLEN_W'(PAT_MAX);

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        StIdle, StLoadStr, StLoadPat, StSearch, StSearchSuf, StDone
    } state_e;

    state_e r_state, w_state_next;

    logic [7:0]        r_str [STR_MAX];
    logic [LEN_W-1:0]  r_str_len;
    logic [7:0]        r_pat [PAT_MAX];
    logic [PLEN_W-1:0] r_pat_len;
    logic [LEN_W-1:0]  r_pos;      // candidate i in SEARCH, j in SEARCH_SUF
    logic [LEN_W-1:0]  r_start;    // i at which the '*' prefix matched
    logic              r_match;
    logic [IDX_W-1:0]  r_index;

    logic             w_caret, w_dollar, w_has_star;
    int               w_star_pos, w_body_start, w_body_end;
    int               w_seg_start, w_seg_len;
    logic             w_chk_caret, w_chk_dollar;
    logic             w_hit, w_at_end, w_valid;
    logic [LEN_W-1:0] w_pre_len;

    // Out-of-range reads return 0 so window positions past the array never match.
    function automatic logic [7:0] str_at(input int idx);
        logic [7:0] c;
        c = 8'h00;
        if (idx >= 0 && idx < int'(STR_MAX)) c = r_str[idx[IDX_W-1:0]];
        return c;
    endfunction

    function automatic logic [7:0] pat_at(input int idx);
        logic [7:0] c;
        c = 8'h00;
        if (idx >= 0 && idx < int'(PAT_MAX)) c = r_pat[idx[PIDX_W-1:0]];
        return c;
    endfunction

    // Decode the stored pattern into anchors and the optional '*' split point.
    always_comb begin
        w_caret    = (r_pat_len != '0) && (r_pat[0] == CH_CARET);
        w_dollar   = 1'b0;
        w_has_star = 1'b0;
        w_star_pos = 0;
        for (int k = 0; k < int'(PAT_MAX); k++) begin
            if (k + 1 == int'(r_pat_len) && r_pat[k] == CH_DOLLAR) w_dollar = 1'b1;
            if (k < int'(r_pat_len) && r_pat[k] == CH_STAR && !w_has_star) begin
                w_has_star = 1'b1;
                w_star_pos = k;
            end
        end
        w_body_start = w_caret ? 1 : 0;
        w_body_end   = w_dollar ? int'(r_pat_len) - 1 : int'(r_pat_len);
    end

    // Full window compare of the active segment (PRE or SUF) at r_pos.
    always_comb begin
        int         pos;
        int         slen;
        int         e;
        logic [7:0] pc;
        pos  = int'(r_pos);
        slen = int'(r_str_len);
        pc   = 8'h00;
        if (r_state == StSearchSuf) begin
            w_seg_start  = w_star_pos + 1;
            w_seg_len    = w_body_end - w_star_pos - 1;
            w_chk_caret  = 1'b0;
            w_chk_dollar = w_dollar;
        end else begin
            w_seg_start  = w_body_start;
            w_seg_len    = w_has_star ? w_star_pos - w_body_start : w_body_end - w_body_start;
            w_chk_caret  = w_caret;
            w_chk_dollar = w_dollar && !w_has_star;
        end
        if (w_seg_len < 0) w_seg_len = 0;

        w_hit = 1'b1;
        if (w_chk_caret && pos != 0 && str_at(pos - 1) != CH_SPACE) w_hit = 1'b0;
        for (int k = 0; k < int'(PAT_MAX); k++) begin
            if (k < w_seg_len) begin
                pc = pat_at(w_seg_start + k);
                if (pos + k >= slen) begin
                    w_hit = 1'b0;
                end else if (pc != CH_DOT && pc != str_at(pos + k)) begin
                    w_hit = 1'b0;
                end
            end
        end
        e = pos + w_seg_len;
        if (w_chk_dollar && e != slen && (e > slen || str_at(e) != CH_SPACE)) w_hit = 1'b0;

        w_at_end  = (r_pos == r_str_len);
        w_pre_len = LEN_W'(w_seg_len);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // Next state; any load strobe pre-empts whatever is in progress (abort).
    always_comb begin
        w_state_next = r_state;
        if (bus.isstring) begin
            w_state_next = StLoadStr;
        end else if (bus.ispattern) begin
            w_state_next = StLoadPat;
        end else begin
            case (r_state)
                StIdle:      w_state_next = StIdle;
                StLoadStr:   w_state_next = StIdle;
                StLoadPat:   w_state_next = StSearch;
                StSearch: begin
                    if (w_hit)         w_state_next = w_has_star ? StSearchSuf : StDone;
                    else if (w_at_end) w_state_next = StDone;
                end
                StSearchSuf: begin
                    if (w_hit || w_at_end) w_state_next = StDone;
                end
                StDone:      w_state_next = StIdle;
                default:     w_state_next = StIdle;
            endcase
        end
    end

    // Outputs; the result is suppressed when the DONE cycle itself is aborted.
    always_comb begin
        w_valid         = (r_state == StDone) && !bus.isstring && !bus.ispattern;
        bus.valid       = w_valid;
        bus.busy        = (r_state == StSearch) || (r_state == StSearchSuf) ||
                          (r_state == StDone);
        bus.match       = w_valid && r_match;
        bus.match_index = w_valid ? r_index : '0;
    end

    // Loading, scan position and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_str_len <= '0;
            r_pat_len <= '0;
            r_pos     <= '0;
            r_start   <= '0;
            r_match   <= 1'b0;
            r_index   <= '0;
        end else begin
            // Being in a load state means the strobe was already high last cycle.
            if (bus.isstring) begin
                if (r_state != StLoadStr) begin
                    r_str[0]  <= bus.chardata;
                    r_str_len <= LEN_W'(1);
                end else if (r_str_len < STR_MAX_L) begin
                    r_str[r_str_len[IDX_W-1:0]] <= bus.chardata;
                    r_str_len <= r_str_len + LEN_W'(1);
                end
            end else if (bus.ispattern) begin
                if (r_state != StLoadPat) begin
                    r_pat[0]  <= bus.chardata;
                    r_pat_len <= PLEN_W'(1);
                end else if (r_pat_len < PAT_MAX_L) begin
                    r_pat[r_pat_len[PIDX_W-1:0]] <= bus.chardata;
                    r_pat_len <= r_pat_len + PLEN_W'(1);
                end
            end

            case (r_state)
                StSearch: begin
                    if (w_hit && w_has_star) begin
                        r_start <= r_pos;
                        r_pos   <= r_pos + w_pre_len;
                    end else begin
                        r_pos <= r_pos + LEN_W'(1);
                    end
                end
                StSearchSuf: r_pos <= r_pos + LEN_W'(1);
                default:     r_pos <= '0;
            endcase

            if (w_state_next == StDone) begin
                r_match <= w_hit;
                if (!w_hit)                       r_index <= '0;
                else if (r_state == StSearchSuf)  r_index <= r_start[IDX_W-1:0];
                else                              r_index <= r_pos[IDX_W-1:0];
            end
        end
    end

endmodule
